// File: rtl/adder_measure_pkg.sv
// Shared types and widths for the adder ring-oscillator measurement controller.
package adder_measure_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned WIN_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      RUN,
      CAPTURE
   } state_t;

endpackage

// File: rtl/adder_measure_sat_counter.sv
// Ring-pulse counter with synchronous clear that sticks at all-ones instead of wrapping.
module adder_measure_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] value,
   output logic [CNT_W-1:0] next_value
);

   always_comb begin
      next_value = value;
      if (clear)
         next_value = '0;
      else if (enable && (value != '1))
         next_value = value + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         value <= '0;
      else
         value <= next_value;
   end

endmodule

// File: rtl/adder_measure_ctrl.sv
// Sequences operand load, settle, ring-oscillator run and result capture.
// Defining ADDER_MEASURE_SUM_CHECK_EN enables the captured-sum comparison on sum_ok.
module adder_measure_ctrl
   import adder_measure_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              active,
   input  logic              start,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic [4:0]        bit_sel,
   input  logic              ext_mode,
   input  logic [WIN_W-1:0]  window,
   input  logic              ring_pulse,
   input  logic [DATA_W-1:0] sum_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [DATA_W-1:0] sel_ext,
   output logic [DATA_W-1:0] sel_ring,
   output logic              ring_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              sum_ok
);

   state_t             state;
   logic [7:0]         settle_cnt;
   logic [WIN_W-1:0]   win_load;
   logic [WIN_W-1:0]   win_cnt;
   logic [CNT_W-1:0]   cnt_value;
   logic [CNT_W-1:0]   cnt_next;
   logic               capture_now;
   logic [DATA_W-1:0]  bit_mask;

   assign bit_mask    = {{(DATA_W-1){1'b0}}, 1'b1} << bit_sel;
   assign capture_now = (state == RUN) && (win_cnt == '0) && active;

   adder_measure_sat_counter #(.CNT_W(CNT_W)) u_counter (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .clear      (state == LOAD),
      .enable     (ring_en && ring_pulse),
      .value      (cnt_value),
      .next_value (cnt_next)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         settle_cnt <= '0;
         win_load   <= '0;
         win_cnt    <= '0;
         a_out      <= '0;
         b_out      <= '0;
         sel_ext    <= '0;
         sel_ring   <= '0;
         ring_en    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         count      <= '0;
      end else if (!active && (state != IDLE)) begin
         state    <= IDLE;
         sel_ext  <= '0;
         sel_ring <= '0;
         ring_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (active && start) begin
                  a_out    <= a_in;
                  b_out    <= b_in;
                  sel_ext  <= ext_mode ? bit_mask : '0;
                  sel_ring <= ext_mode ? '0 : bit_mask;
                  // Stored as cycles-minus-one so a zero window still yields one RUN cycle.
                  win_load <= (window == '0) ? '0 : window - WIN_W'(1);
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               settle_cnt <= 8'(SETTLE_CYCLES - 1);
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  win_cnt <= win_load;
                  ring_en <= 1'b1;
                  state   <= RUN;
               end else begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            RUN: begin
               if (capture_now) begin
                  // Take the counter's next value so a pulse in the final RUN cycle is included.
                  count    <= cnt_next;
                  ring_en  <= 1'b0;
                  sel_ext  <= '0;
                  sel_ring <= '0;
                  done     <= 1'b1;
                  state    <= CAPTURE;
               end else begin
                  win_cnt <= win_cnt - WIN_W'(1);
               end
            end
            CAPTURE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADDER_MEASURE_SUM_CHECK_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         sum_ok <= 1'b0;
      else if (capture_now)
         sum_ok <= (sum_in == (a_out + b_out));
   end
`else
   logic unused_sum;
   assign unused_sum = ^sum_in;
   assign sum_ok     = 1'b0;
`endif

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Scoreboard bench for adder_measure_ctrl: expected results queued at start, checked on done.
module tb_adder_measure_ctrl;

`ifdef ADDER_MEASURE_SUM_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, active, start, ext_mode, ring_pulse;
   logic [31:0] a_in, b_in, sum_in;
   logic [4:0]  bit_sel;
   logic [15:0] window;
   logic [31:0] a_out, b_out, sel_ext, sel_ring, count;
   logic        ring_en, busy, done, sum_ok;
   logic [31:0] a_out4, b_out4, sel_ext4, sel_ring4;
   logic [3:0]  count4;
   logic        ring_en4, busy4, done4, sum_ok4;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int          pulse_mode = 0;

   typedef struct {
      logic [31:0] count;
      logic        sum_ok;
      bit          use4;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   adder_measure_ctrl #(.SETTLE_CYCLES(4), .CNT_W(32)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
      .a_in(a_in), .b_in(b_in), .bit_sel(bit_sel), .ext_mode(ext_mode),
      .window(window), .ring_pulse(ring_pulse), .sum_in(sum_in),
      .a_out(a_out), .b_out(b_out), .sel_ext(sel_ext), .sel_ring(sel_ring),
      .ring_en(ring_en), .busy(busy), .done(done), .count(count), .sum_ok(sum_ok)
   );

   adder_measure_ctrl #(.SETTLE_CYCLES(4), .CNT_W(4)) dut4 (
      .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
      .a_in(a_in), .b_in(b_in), .bit_sel(bit_sel), .ext_mode(ext_mode),
      .window(window), .ring_pulse(ring_pulse), .sum_in(sum_in),
      .a_out(a_out4), .b_out(b_out4), .sel_ext(sel_ext4), .sel_ring(sel_ring4),
      .ring_en(ring_en4), .busy(busy4), .done(done4), .count(count4), .sum_ok(sum_ok4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      case (pulse_mode)
         1:       ring_pulse = ~ring_pulse;
         2:       ring_pulse = 1'b1;
         default: ring_pulse = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.use4) check("count_sat", {28'd0, count4}, e.count);
            else        check("count", count, e.count);
            check("sum_ok", {31'd0, sum_ok}, {31'd0, e.sum_ok});
         end
      end
   end

   // Called at a negedge; drives start immediately and returns at the negedge after done.
   task automatic run_meas(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel,
                           input logic ext, input logic [15:0] win, input int pm,
                           input logic [31:0] sumv, input logic [31:0] exp_cnt,
                           input bit use4, input bit restart);
      exp_t        e;
      logic [31:0] mask, sum_ab;
      int          lat, run_cycles, eff, exp_lat;
      bit          seen_run;
      sum_ab   = a + b;
      mask     = 32'd1 << sel;
      eff      = (win == 16'd0) ? 1 : int'(win);
      exp_lat  = 1 + 4 + eff + 1;
      e.count  = exp_cnt;
      e.sum_ok = CHK_EN && (sumv == sum_ab);
      e.use4   = use4;
      a_in = a; b_in = b; bit_sel = sel; ext_mode = ext; window = win;
      sum_in = sumv; pulse_mode = pm; start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1; run_cycles = 0; seen_run = 0;
      while (!done && lat < 2000) begin
         if (ring_en) begin
            run_cycles++;
            if (!seen_run) begin
               seen_run = 1;
               check("sel_ext", sel_ext, ext ? mask : 32'd0);
               check("sel_ring", sel_ring, ext ? 32'd0 : mask);
               check("a_out", a_out, a);
               check("b_out", b_out, b);
            end
         end
         start = (restart && lat == 5) ? 1'b1 : 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      check("run_cycles", 32'(run_cycles), 32'(eff));
      check("capture_ring_en", {31'd0, ring_en}, 32'd0);
      check("capture_masks", sel_ext | sel_ring, 32'd0);
      pulse_mode = 0;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_a_hold", a_out, a);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"}, a_out, 32'd0);
      check({tag, "_b"}, b_out, 32'd0);
      check({tag, "_masks"}, sel_ext | sel_ring, 32'd0);
      check({tag, "_count"}, count, 32'd0);
      check({tag, "_flags"}, {28'd0, ring_en, busy, done, sum_ok}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; active = 1'b1; start = 1'b0; ext_mode = 1'b0; ring_pulse = 1'b0;
      a_in = '0; b_in = '0; sum_in = '0; bit_sel = '0; window = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      run_meas(32'd3, 32'd5, 5'd9, 1'b0, 16'd10, 1, 32'd8, 32'd5, 0, 0);
      run_meas(32'd3, 32'd5, 5'd9, 1'b0, 16'd10, 1, 32'd9, 32'd5, 0, 0);
      run_meas(32'hFFFF_FFFF, 32'd2, 5'd31, 1'b1, 16'd0, 2, 32'd1, 32'd1, 0, 0);
      run_meas(32'd7, 32'd7, 5'd0, 1'b0, 16'd40, 2, 32'd14, 32'd15, 1, 0);
      run_meas(32'd1, 32'd2, 5'd4, 1'b1, 16'd6, 1, 32'd3, 32'd3, 0, 1);
      repeat (20) @(negedge clk);

      // Abort during RUN: count must keep the previous result (3).
      window = 16'd20; pulse_mode = 2; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!ring_en && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("abort_reached_run", {31'd0, ring_en}, 32'd1);
      repeat (3) @(negedge clk);
      active = 1'b0;
      @(negedge clk);
      check("abort_ring_en", {31'd0, ring_en}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_masks", sel_ext | sel_ring, 32'd0);
      check("abort_count", count, 32'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("inactive_start", {31'd0, busy}, 32'd0);
      pulse_mode = 0;
      repeat (30) @(negedge clk);
      active = 1'b1;
      @(negedge clk);

      // Reset mid-SETTLE, then a start in the very next cycle.
      window = 16'd8; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      rst = 1'b0;
      run_meas(32'd10, 32'd20, 5'd2, 1'b0, 16'd3, 2, 32'd30, 32'd3, 0, 0);

      repeat (10) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_measure_ctrl.md
ADDER_MEASURE_CTRL -- requirements
Module: adder_measure_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, cycles operands are held before ring enable (range 1..255).
REQ-002 Parameter CNT_W, default 32, width of the ring-pulse counter and the count output.
REQ-003 Port wb_clk_i  in  1  sole clock; all state is updated on its rising edge.
REQ-004 Port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 Port active  in  1  design-select; low forces the block idle.
REQ-006 Port start  in  1  one-cycle measurement request.
REQ-007 Port a_in, b_in  in  32 each  operands sampled at accepted start.
REQ-008 Port bit_sel  in  5  adder bit routed into the ring, sampled at accepted start.
REQ-009 Port ext_mode  in  1  1 selects the external-path mask, 0 the ring-path mask, sampled at accepted start.
REQ-010 Port window  in  16  measurement length in cycles, sampled at accepted start; 0 is treated as 1.
REQ-011 Port ring_pulse  in  1  already-synchronised one-cycle pulse per ring-oscillator period.
REQ-012 Port sum_in  in  32  adder sum output.
REQ-013 Port a_out, b_out  out  32 each  registered operands driving the adder.
REQ-014 Port sel_ext, sel_ring  out  32 each  one-hot bit-select masks; at most one is non-zero.
REQ-015 Port ring_en  out  1  ring-oscillator enable.
REQ-016 Port busy  out  1  high from LOAD through CAPTURE.
REQ-017 Port done  out  1  one-cycle pulse when results are valid.
REQ-018 Port count  out  CNT_W  ring pulses counted in the last window, held until the next done.
REQ-019 Port sum_ok  out  1  last captured sum equals a_out+b_out mod 2^32, held until the next done.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, SETTLE, RUN and CAPTURE.
REQ-021 In IDLE with active=1 and start=1, the FSM SHALL register operands and config, then go to LOAD.
REQ-022 start SHALL be ignored when busy=1 or active=0, and SHALL NOT be queued.
REQ-023 LOAD SHALL last 1 cycle: drive a_out/b_out, set the single mask bit bit_sel in sel_ext (ext_mode=1) or sel_ring (ext_mode=0), clear the counter, then go to SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to RUN.
REQ-025 RUN SHALL hold ring_en=1 for exactly max(window,1) cycles and increment the counter on each ring_pulse seen while ring_en=1.
REQ-026 The counter SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 CAPTURE SHALL last 1 cycle: ring_en=0, masks cleared, count and sum_ok updated, done=1, then go to IDLE.
REQ-028 A ring_pulse coincident with the last RUN cycle SHALL be counted; a pulse in CAPTURE SHALL NOT be counted.
REQ-029 Latency from accepted start to done SHALL be 1+SETTLE_CYCLES+max(window,1)+1 cycles.
REQ-030 If active falls in any non-IDLE state, the FSM SHALL enter IDLE next cycle, clear ring_en and the masks, leave count and sum_ok unchanged, and SHALL NOT pulse done.
REQ-031 a_out and b_out SHALL retain their last values in IDLE.

Reset
REQ-032 With wb_rst_i=1 at a clock edge, state SHALL become IDLE; a_out, b_out, sel_ext, sel_ring, count=0; ring_en, busy, done, sum_ok=0.
REQ-033 Reset SHALL take priority over start and active in the same cycle, including mid-measurement.

Configuration
REQ-034 Macro ADDER_MEASURE_SUM_CHECK_EN SHALL control the sum check.
REQ-035 With the macro defined, sum_ok SHALL be computed at CAPTURE per REQ-019.
REQ-036 Without the macro, sum_ok SHALL be constant 0, sum_in SHALL be unused, and no comparator SHALL be synthesised.

Structure
REQ-037 Package adder_measure_pkg SHALL hold the state enum, the 32-bit data width constant and the 16-bit window width constant.
REQ-038 The saturating counter SHALL be the sub-module adder_measure_sat_counter, with clear, enable and saturation.

Verification
REQ-039 Scenario: a=3, b=5, bit_sel=9, ext_mode=0, window=10, one ring_pulse every 2nd cycle -> sel_ring=0x200 during the run; done 16 cycles after start; count=5; sum_in=8 gives sum_ok=1.
REQ-040 Scenario: same run with sum_in=9 -> sum_ok=0; with the macro undefined -> sum_ok=0 always.
REQ-041 Scenario: window=0, ring_pulse constantly high -> exactly 1 RUN cycle; count=1; done at cycle 7.
REQ-042 Scenario: CNT_W=4, window=40, ring_pulse constantly high -> count=15 (saturated).
REQ-043 Scenario: active dropped during RUN -> ring_en=0 next cycle, no done, count keeps its previous value; a new start while busy -> ignored.
REQ-044 Scenario: wb_rst_i asserted mid-SETTLE -> all outputs 0 next cycle; a start the cycle after reset is accepted.
